axi_rd_arbiter: RTL

- Shares the single AXI read channel (AR/R) between the instruction-cache refill port (requester 0) and the data-cache refill/uncached-load port (requester 1).
- Allows one outstanding burst at a time. Each request is latched at grant and held stable on AR until accepted. R beats are routed back to the owning cache.
- Sits between the cache pair and the top-level AXI bridge, and feeds `data_cache_data_ok`/`data_cache_rdata` timing upstream of the MEM stage.

---
 rtl/axi_rd_arbiter_pkg.sv | 18 +
 rtl/axi_rd_arbiter_if.sv | 30 +++
 rtl/axi_rd_arbiter_rr_arb2.sv | 38 +++
 rtl/axi_rd_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter.
// Holds the AXI burst encoding, the AR id encodings for the two requesters
// and the arbiter FSM state type.
package axi_rd_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // arid values; the instruction side is requester 0, the data side is 1
  localparam int unsigned ARID_INST = 0;
  localparam int unsigned ARID_DATA = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel (AR + R) bundle between the arbiter and the AXI bridge.
// Modports:
//   master - the arbiter side: drives ar* and rready, receives arready and r*
//   slave  - the bridge side: the mirror image of master
interface axi_rd_arbiter_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   req[1:0]    - request lines (bit 0 inst, bit 1 data)
//   take        - the caller accepts the current grant this cycle
//   grant_valid - at least one request is pending
//   grant_idx   - index of the granted requester
module axi_rd_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant;

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (take && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the I-cache refill port (requester 0)
// and the D-cache refill / uncached-load port (requester 1). One burst is in
// flight at a time; the request is latched at grant and held on AR until
// accepted, then R beats are passed straight through to the owner.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   i_* / d_*           - requester request, address-accept pulse and R beats
//   bus                 - AXI AR/R channel (master side)
//   len_err             - sticky error: wrong beat count at rlast or rid mismatch
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [2:0]       i_size,
  output logic             i_addr_ok,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_rlast,
  input  logic             d_req,
  input  logic [31:0]      d_addr,
  input  logic [LEN_W-1:0] d_len,
  input  logic [2:0]       d_size,
  output logic             d_addr_ok,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_rlast,
  axi_rd_arbiter_if.master bus,
  output logic             len_err
);

  state_e state, state_next;

  logic [ID_W-1:0]  arid_q;
  logic [31:0]      araddr_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       size_q;
  logic [LEN_W-1:0] beat_cnt;

  logic grant_valid;
  logic grant_idx;
  logic owner_data;
  logic arvalid_c;
  logic rready_c;

  axi_rd_arbiter_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req         ({d_req, i_req}),
    .take        (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign owner_data = (arid_q == ID_W'(ARID_DATA));

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'(len_q);
  assign bus.arsize  = size_q;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arvalid = arvalid_c;
  assign bus.rready  = rready_c;

  // Read data goes to both ports; only the owner's rvalid qualifies it.
  assign i_rdata = bus.rdata;
  assign d_rdata = bus.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus all handshake outputs; beats are forwarded in the same
  // cycle they arrive, so rvalid/rlast reach the owner combinationally.
  always_comb begin
    state_next = state;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    i_addr_ok  = 1'b0;
    d_addr_ok  = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rlast    = 1'b0;
    d_rlast    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        arvalid_c = 1'b1;
        if (bus.arready) begin
          i_addr_ok  = ~owner_data;
          d_addr_ok  = owner_data;
          state_next = ST_R;
        end
      end
      ST_R: begin
        rready_c = 1'b1;
        if (bus.rvalid) begin
          i_rvalid = ~owner_data;
          d_rvalid = owner_data;
          i_rlast  = ~owner_data & bus.rlast;
          d_rlast  = owner_data & bus.rlast;
          if (bus.rlast) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch at grant, beat counting and the sticky protocol check.
  always_ff @(posedge clk) begin
    if (reset) begin
      arid_q   <= '0;
      araddr_q <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            arid_q   <= grant_idx ? ID_W'(ARID_DATA) : ID_W'(ARID_INST);
            araddr_q <= grant_idx ? d_addr : i_addr;
            len_q    <= grant_idx ? d_len : i_len;
            size_q   <= grant_idx ? d_size : i_size;
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            beat_cnt <= '0;
          end
        end
        ST_R: begin
          if (bus.rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if ((bus.rid != arid_q) || (bus.rlast && (beat_cnt != len_q))) begin
              len_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
